// File: rtl/common_pkg.sv
// Shared bus geometry for the RAM subsystem.
package common_pkg;

    localparam int RAM_ADDR_WIDTH = 17;
    localparam int DATA_WIDTH     = 8;

endpackage

// File: rtl/ram_arbiter.sv
// Two-master Wishbone B4 pipelined arbiter in front of a single RAM port.
// Carries one transaction at a time; port 0 is preferred, with bounded starvation of port 1.
module ram_arbiter
    import common_pkg::*;
#(
    parameter int MAX_CONSECUTIVE = 3
) (
    input  logic                      wb_clock_i,
    input  logic                      wb_reset_ni,

    input  logic [RAM_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0]     m0_data_i,
    input  logic                      m0_we_i,
    input  logic                      m0_cycle_i,
    input  logic                      m0_strobe_i,
    output logic                      m0_stall_o,
    output logic                      m0_ack_o,

    input  logic [RAM_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0]     m1_data_i,
    input  logic                      m1_we_i,
    input  logic                      m1_cycle_i,
    input  logic                      m1_strobe_i,
    output logic                      m1_stall_o,
    output logic                      m1_ack_o,

    output logic [DATA_WIDTH-1:0]     m_data_o,

    output logic [RAM_ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0]     s_data_o,
    output logic                      s_we_o,
    output logic                      s_cycle_o,
    output logic                      s_strobe_o,
    input  logic                      s_stall_i,
    input  logic                      s_ack_i,
    input  logic [DATA_WIDTH-1:0]     s_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK
    } state_t;

    localparam int                CNT_W   = $clog2(MAX_CONSECUTIVE + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_CONSECUTIVE);

    state_t             state, state_nxt;
    logic               owner, owner_nxt;
    logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;

    logic               req0, req1, grant1, owner_cycle;

    assign req0        = m0_cycle_i && m0_strobe_i;
    assign req1        = m1_cycle_i && m1_strobe_i;
    // Port 1 wins only when alone or once port 0 has used up its run of consecutive grants.
    assign grant1      = req1 && (!req0 || (starve_cnt == CNT_MAX));
    assign owner_cycle = owner ? m1_cycle_i : m0_cycle_i;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            starve_cnt <= starve_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        starve_cnt_nxt = starve_cnt;
        s_cycle_o      = 1'b0;
        s_strobe_o     = 1'b0;
        m0_stall_o     = 1'b1;
        m1_stall_o     = 1'b1;

        if (!req1) begin
            starve_cnt_nxt = '0;
        end

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    owner_nxt = grant1;
                    state_nxt = ISSUE;
                    if (grant1) begin
                        starve_cnt_nxt = '0;
                    end else if (req1 && (starve_cnt != CNT_MAX)) begin
                        starve_cnt_nxt = starve_cnt + 1'b1;
                    end
                end
            end
            ISSUE: begin
                s_cycle_o = 1'b1;
                if (!owner_cycle) begin
                    state_nxt = IDLE;
                end else begin
                    s_strobe_o = 1'b1;
                    if (!s_stall_i) begin
                        state_nxt = WAIT_ACK;
                        if (owner) m1_stall_o = 1'b0;
                        else       m0_stall_o = 1'b0;
                    end
                end
            end
            WAIT_ACK: begin
                // The ack is awaited even if the owner abandoned its cycle; it is then discarded.
                s_cycle_o = 1'b1;
                if (s_ack_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_addr_o = owner ? m1_addr_i : m0_addr_i;
    assign s_data_o = owner ? m1_data_i : m0_data_i;
    assign s_we_o   = owner ? m1_we_i   : m0_we_i;
    assign m_data_o = s_data_i;

    assign m0_ack_o = s_ack_i && (state == WAIT_ACK) && !owner && m0_cycle_i;
    assign m1_ack_o = s_ack_i && (state == WAIT_ACK) &&  owner && m1_cycle_i;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized reactive masters.
`timescale 1ns/1ps
module tb_ram_arbiter;
    import common_pkg::*;

    localparam int MAXC = 3;
    localparam int AW   = RAM_ADDR_WIDTH;
    localparam int DW   = DATA_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic [DW-1:0] m0_data_i, m1_data_i;
    logic          m0_we_i, m1_we_i, m0_cycle_i, m1_cycle_i, m0_strobe_i, m1_strobe_i;
    logic          m0_stall_o, m1_stall_o, m0_ack_o, m1_ack_o;
    logic [DW-1:0] m_data_o;
    logic [AW-1:0] s_addr_o;
    logic [DW-1:0] s_data_o, s_data_i;
    logic          s_we_o, s_cycle_o, s_strobe_o, s_stall_i, s_ack_i;

    ram_arbiter #(.MAX_CONSECUTIVE(MAXC)) dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i),
        .m0_cycle_i(m0_cycle_i), .m0_strobe_i(m0_strobe_i),
        .m0_stall_o(m0_stall_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i),
        .m1_cycle_i(m1_cycle_i), .m1_strobe_i(m1_strobe_i),
        .m1_stall_o(m1_stall_o), .m1_ack_o(m1_ack_o),
        .m_data_o(m_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
        .s_cycle_o(s_cycle_o), .s_strobe_o(s_strobe_o),
        .s_stall_i(s_stall_i), .s_ack_i(s_ack_i), .s_data_i(s_data_i)
    );

    // RAM model: stalls for stall_req-stall_used strobe cycles, acks 3 edges after acceptance.
    int            ram_cnt    = 0;
    int            stall_used = 0;
    int            stall_req  = 0;
    logic [DW-1:0] ram_rdata  = '0;
    logic          acc_n      = 1'b0;
    logic          stl_n      = 1'b0;

    assign s_stall_i = (stall_used < stall_req);
    assign s_ack_i   = (ram_cnt == 1);
    assign s_data_i  = s_ack_i ? ram_rdata : '0;

    always @(posedge clk) begin
        if (acc_n)            ram_cnt <= 3;
        else if (ram_cnt > 0) ram_cnt <= ram_cnt - 1;
        if (stl_n)            stall_used <= stall_used + 1;
    end

    // Monitor, sampled mid-cycle.
    int            acc_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, overlap_err = 0;
    logic          outstanding = 1'b0;
    logic [AW-1:0] acc_addr_mem [0:255];
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0, ack0_data = '0, mdata_s = '0;
    logic          last_we = 1'b0;
    logic [1:0]    stall_s = 2'b11, ack_s = 2'b00;

    always @(negedge clk) begin
        acc_n   <= s_cycle_o && s_strobe_o && !s_stall_i;
        stl_n   <= s_cycle_o && s_strobe_o &&  s_stall_i;
        stall_s <= {m1_stall_o, m0_stall_o};
        ack_s   <= {m1_ack_o, m0_ack_o};
        mdata_s <= m_data_o;
        if (s_ack_i) outstanding <= 1'b0;
        if (s_cycle_o && s_strobe_o && !s_stall_i) begin
            acc_addr_mem[acc_cnt % 256] <= s_addr_o;
            last_addr   <= s_addr_o;
            last_data   <= s_data_o;
            last_we     <= s_we_o;
            acc_cnt     <= acc_cnt + 1;
            if (outstanding) overlap_err <= overlap_err + 1;
            outstanding <= 1'b1;
        end
        if (m0_ack_o) begin
            ack0_cnt  <= ack0_cnt + 1;
            ack0_data <= m_data_o;
        end
        if (m1_ack_o) ack1_cnt <= ack1_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic cyc, input logic stb,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
        if (p == 0) begin
            m0_cycle_i = cyc; m0_strobe_i = stb; m0_addr_i = a; m0_data_i = d; m0_we_i = we;
        end else begin
            m1_cycle_i = cyc; m1_strobe_i = stb; m1_addr_i = a; m1_data_i = d; m1_we_i = we;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 17'h00042, 8'h00, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
        tick();
        checks++;
        if ({s_cycle_o, s_strobe_o, m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o} !== 6'b000011) begin
            failures++;
            $display("FAIL reset_outputs: got cyc/stb/ack0/ack1/stall0/stall1=%b required 000011",
                     {s_cycle_o, s_strobe_o, m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o});
        end
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        tick();
        checks++;
        if (s_cycle_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: s_cycle_o=%b required 0", s_cycle_o);
        end
    endtask

    task automatic test_read();
        int a0 = ack0_cnt, a1 = ack1_cnt, ac = acc_cnt;
        ram_rdata = 8'hA5;
        drive(0, 1'b1, 1'b1, 17'h1F000, 8'h00, 1'b0);
        #1;
        checks++;
        if (s_strobe_o !== 1'b0) begin
            failures++; $display("FAIL read_no_early_strobe: s_strobe_o=%b required 0", s_strobe_o);
        end
        tick();
        checks++;
        if ({s_strobe_o, s_we_o, s_addr_o} !== {1'b1, 1'b0, 17'h1F000}) begin
            failures++;
            $display("FAIL read_issue: stb=%b we=%b addr=%h required 1 0 1f000", s_strobe_o, s_we_o, s_addr_o);
        end
        tick();
        drive(0, 1'b1, 1'b0, 17'h1F000, 8'h00, 1'b0);
        repeat (6) tick();
        checks++;
        if ({ack0_cnt - a0, ack1_cnt - a1, acc_cnt - ac} !== {32'd1, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL read_acks: ack0=%0d ack1=%0d accepts=%0d required 1 0 1",
                     ack0_cnt - a0, ack1_cnt - a1, acc_cnt - ac);
        end
        checks++;
        if (ack0_data !== 8'hA5) begin
            failures++; $display("FAIL read_data: m_data_o=%h required a5", ack0_data);
        end
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_fairness();
        int base = acc_cnt;
        int n;
        logic [AW-1:0] exp_a;
        drive(0, 1'b1, 1'b1, 17'h00100, 8'h11, 1'b0);
        drive(1, 1'b1, 1'b1, 17'h00200, 8'h22, 1'b0);
        n = 0;
        while ((acc_cnt - base) < 8 && n < 200) begin
            tick();
            n++;
        end
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        checks++;
        if ((acc_cnt - base) < 8) begin
            failures++; $display("FAIL fair_timeout: accepts=%0d required 8", acc_cnt - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_a = ((k % (MAXC + 1)) == MAXC) ? 17'h00200 : 17'h00100;
                checks++;
                if (acc_addr_mem[(base + k) % 256] !== exp_a) begin
                    failures++;
                    $display("FAIL fair_order[%0d]: addr=%h required %h", k, acc_addr_mem[(base + k) % 256], exp_a);
                end
            end
        end
        repeat (8) tick();
    endtask

    task automatic test_stall();
        int a1 = ack1_cnt, ac = acc_cnt;
        stall_req = stall_used + 4;
        drive(1, 1'b1, 1'b1, 17'h00010, 8'h3C, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_strobe_o, m1_stall_o, s_we_o, s_data_o, s_addr_o} !== {1'b1, 1'b1, 1'b1, 8'h3C, 17'h00010}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: stb=%b stall1=%b we=%b data=%h addr=%h required 1 1 1 3c 00010",
                         i, s_strobe_o, m1_stall_o, s_we_o, s_data_o, s_addr_o);
            end
            tick();
        end
        checks++;
        if ({s_strobe_o, m1_stall_o} !== 2'b10) begin
            failures++; $display("FAIL stall_release: stb=%b stall1=%b required 1 0", s_strobe_o, m1_stall_o);
        end
        tick();
        drive(1, 1'b1, 1'b0, 17'h00010, 8'h3C, 1'b1);
        repeat (6) tick();
        checks++;
        if ({acc_cnt - ac, ack1_cnt - a1} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL stall_single: accepts=%0d ack1=%0d required 1 1", acc_cnt - ac, ack1_cnt - a1);
        end
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_abort();
        int a0 = ack0_cnt, a1 = ack1_cnt, ac = acc_cnt;
        drive(0, 1'b1, 1'b1, 17'h00300, 8'h00, 1'b0);
        drive(1, 1'b1, 1'b1, 17'h00400, 8'h00, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0, 17'h00300, 8'h00, 1'b0);
        #1;
        checks++;
        if ({s_strobe_o, m0_stall_o} !== 2'b01) begin
            failures++; $display("FAIL abort_strobe: stb=%b stall0=%b required 0 1", s_strobe_o, m0_stall_o);
        end
        tick();
        tick();
        checks++;
        if ({s_strobe_o, m1_stall_o, s_addr_o} !== {1'b1, 1'b0, 17'h00400}) begin
            failures++;
            $display("FAIL abort_m1_grant: stb=%b stall1=%b addr=%h required 1 0 00400", s_strobe_o, m1_stall_o, s_addr_o);
        end
        tick();
        drive(1, 1'b1, 1'b0, 17'h00400, 8'h00, 1'b0);
        repeat (6) tick();
        checks++;
        if ({acc_cnt - ac, ack0_cnt - a0, ack1_cnt - a1, last_addr} !== {32'd1, 32'd0, 32'd1, 17'h00400}) begin
            failures++;
            $display("FAIL abort_counts: accepts=%0d ack0=%0d ack1=%0d addr=%h required 1 0 1 00400",
                     acc_cnt - ac, ack0_cnt - a0, ack1_cnt - a1, last_addr);
        end
        drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_reset_mid();
        int a0 = ack0_cnt;
        drive(0, 1'b1, 1'b1, 17'h00500, 8'h00, 1'b0);
        tick();
        tick();
        drive(0, 1'b1, 1'b0, 17'h00500, 8'h00, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_cycle_o, s_strobe_o, m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o} !== 6'b000011) begin
            failures++;
            $display("FAIL reset_async: cyc/stb/ack0/ack1/stall0/stall1=%b required 000011",
                     {s_cycle_o, s_strobe_o, m0_ack_o, m1_ack_o, m0_stall_o, m1_stall_o});
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({s_ack_i, m0_ack_o} !== 2'b10) begin
            failures++; $display("FAIL reset_late_ack: s_ack_i=%b m0_ack_o=%b required 1 0", s_ack_i, m0_ack_o);
        end
        repeat (3) tick();
        checks++;
        if (ack0_cnt - a0 !== 0) begin
            failures++; $display("FAIL reset_no_ack: ack0=%0d required 0", ack0_cnt - a0);
        end
        drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
        tick();
    endtask

    task automatic test_random();
        localparam int N = 12;
        int            phase [2];
        int            gap   [2];
        int            done  [2];
        logic [AW-1:0] caddr [2];
        logic [DW-1:0] cdata [2];
        logic          cwe   [2];
        logic [DW-1:0] exp_rd[2];
        int            cycles = 0;
        int            ov0 = overlap_err;
        for (int p = 0; p < 2; p++) begin
            phase[p] = 0; gap[p] = p; done[p] = 0;
            caddr[p] = '0; cdata[p] = '0; cwe[p] = 1'b0; exp_rd[p] = '0;
        end
        while ((done[0] < N || done[1] < N) && cycles < 3000) begin
            tick();
            cycles++;
            for (int p = 0; p < 2; p++) begin
                case (phase[p])
                    0: if (done[p] < N) begin
                        if (gap[p] == 0) begin
                            caddr[p] = AW'($urandom);
                            cdata[p] = DW'($urandom);
                            cwe[p]   = 1'($urandom_range(0, 1));
                            drive(p, 1'b1, 1'b1, caddr[p], cdata[p], cwe[p]);
                            phase[p] = 1;
                        end else begin
                            gap[p]--;
                        end
                    end
                    1: if (!stall_s[p]) begin
                        checks++;
                        if ({last_we, last_addr, last_data} !== {cwe[p], caddr[p], cdata[p]}) begin
                            failures++;
                            $display("FAIL rand_accept_m%0d: we/addr/data=%b/%h/%h required %b/%h/%h",
                                     p, last_we, last_addr, last_data, cwe[p], caddr[p], cdata[p]);
                        end
                        ram_rdata = DW'($urandom);
                        exp_rd[p] = ram_rdata;
                        drive(p, 1'b1, 1'b0, caddr[p], cdata[p], cwe[p]);
                        phase[p] = 2;
                    end
                    2: if (ack_s[p]) begin
                        checks++;
                        if (mdata_s !== exp_rd[p]) begin
                            failures++;
                            $display("FAIL rand_ack_data_m%0d: m_data_o=%h required %h", p, mdata_s, exp_rd[p]);
                        end
                        drive(p, 1'b0, 1'b0, '0, '0, 1'b0);
                        done[p]++;
                        phase[p] = 0;
                        gap[p]   = int'($urandom_range(0, 3));
                    end
                    default: phase[p] = 0;
                endcase
            end
            if (stall_req <= stall_used && $urandom_range(0, 3) == 0)
                stall_req = stall_used + int'($urandom_range(0, 2));
        end
        checks++;
        if (done[0] < N || done[1] < N) begin
            failures++; $display("FAIL rand_timeout: done0=%0d done1=%0d required %0d each", done[0], done[1], N);
        end
        checks++;
        if (overlap_err - ov0 !== 0) begin
            failures++; $display("FAIL rand_single_outstanding: overlaps=%0d required 0", overlap_err - ov0);
        end
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_read();
        test_fairness();
        test_stall();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: MAX_CONSECUTIVE, default 3, maximum consecutive port-0 grants while port 1 waits.
REQ-002 wb_clock_i  in  1  single clock for all logic.
REQ-003 wb_reset_ni  in  1  reset, asynchronous assert, active-low.
REQ-004 mN_addr_i (N=0,1)  in  RAM_ADDR_WIDTH  master N address.
REQ-005 mN_data_i  in  DATA_WIDTH  master N write data.
REQ-006 mN_we_i  in  1  master N write enable.
REQ-007 mN_cycle_i / mN_strobe_i  in  1 each  master N Wishbone B4 pipelined cycle/strobe.
REQ-008 mN_stall_o  out  1  master N stall.
REQ-009 mN_ack_o  out  1  master N acknowledge.
REQ-010 m_data_o  out  DATA_WIDTH  read data, shared by both masters, equal to s_data_i.
REQ-011 s_addr_o / s_data_o / s_we_o  out  RAM_ADDR_WIDTH / DATA_WIDTH / 1  to RAM peripheral.
REQ-012 s_cycle_o / s_strobe_o  out  1 each  to RAM peripheral.
REQ-013 s_stall_i / s_ack_i  in  1 each  from RAM peripheral.
REQ-014 s_data_i  in  DATA_WIDTH  read data from RAM peripheral.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_ACK, with a registered owner bit.
REQ-016 A port SHALL request when mN_cycle_i && mN_strobe_i.
REQ-017 IDLE: with any request present, owner SHALL latch the winner and the state SHALL go to ISSUE on the next edge; with no request, the state SHALL stay IDLE.
REQ-018 Winner SHALL be port 0 unless port 1 requests and the starvation count equals MAX_CONSECUTIVE; a lone requester SHALL always win.
REQ-019 Starvation count SHALL increment on each port-0 grant while port 1 requests, and SHALL clear on a port-1 grant or whenever port 1 is not requesting; it SHALL saturate at MAX_CONSECUTIVE.
REQ-020 ISSUE: s_cycle_o=s_strobe_o=1, and s_addr_o/s_data_o/s_we_o SHALL combinationally equal the owner's inputs.
REQ-021 ISSUE with !s_stall_i: transfer accepted; owner's mN_stall_o SHALL be 0 that cycle only; next state SHALL be WAIT_ACK.
REQ-022 ISSUE with s_stall_i: the state SHALL hold with all outputs unchanged.
REQ-023 ISSUE with owner's mN_cycle_i low (abort): s_strobe_o SHALL be 0 and the state SHALL return to IDLE without issuing.
REQ-024 WAIT_ACK: s_cycle_o=1, s_strobe_o=0; on s_ack_i the state SHALL return to IDLE.
REQ-025 mN_ack_o SHALL equal s_ack_i && state==WAIT_ACK && owner==N && mN_cycle_i; if the owner drops its cycle mid-wait, the arbiter SHALL still wait for s_ack_i, which SHALL be discarded.
REQ-026 mN_stall_o SHALL be 1 in all cases not covered by REQ-021, including for the non-owner.
REQ-027 At most one transaction SHALL be outstanding; a new arbitration SHALL occur only in IDLE, so the minimum spacing between accepted strobes is 1 ack cycle plus 2 cycles.
REQ-028 s_ack_i outside WAIT_ACK SHALL be ignored.

Reset
REQ-029 Assertion of wb_reset_ni low SHALL immediately force state=IDLE, owner=0, starvation count=0, s_cycle_o=s_strobe_o=0, mN_ack_o=0, mN_stall_o=1, independent of the clock.
REQ-030 Reset asserted mid-transaction SHALL abandon it; no ack SHALL be forwarded after release until a new grant.
REQ-031 s_addr_o/s_data_o/s_we_o SHALL be don't-care while s_cycle_o=0.

Structure
REQ-032 RAM_ADDR_WIDTH and DATA_WIDTH SHALL come from common_pkg; the state enum type SHALL be defined locally.
REQ-033 The design SHALL be a single flat module with no sub-modules; the RAM peripheral SHALL be instantiated alongside it, not inside it.

Verification (RAM model: stall=0 when idle, ack 3 cycles after acceptance)
REQ-034 m0 read at 0x1F000, RAM returns 0xA5 -> s_strobe_o high one cycle after request, m0_ack_o one cycle with m_data_o=0xA5, m1_ack_o=0.
REQ-035 m0 and m1 request continuously -> grant order 0,0,0,1,0,0,0,1.
REQ-036 m1 write 0x3C at 0x00010 while model stalls for 4 cycles -> ISSUE held, m1_stall_o=1 throughout, single accepted strobe, s_we_o=1, s_data_o=0x3C.
REQ-037 m0 drops cycle in ISSUE -> no s_strobe_o accepted, return to IDLE, pending m1 granted next.
REQ-038 wb_reset_ni pulsed low during WAIT_ACK -> outputs at reset values within the same cycle, late s_ack_i produces no mN_ack_o.
